fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 57600, number of frame-buffer pixel words (320x180).
REQ-002 SHALL have parameter ADDR_W, default 16, frame-buffer address width; FB_DEPTH <= 2**ADDR_W.
REQ-003 SHALL have parameter DATA_W, default 16, pixel word width (RGB565).
REQ-004 SHALL have port clk_in, input, 1, the single system clock; all logic in this domain.
REQ-005 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports req0_valid_in input 1, req0_addr_in input ADDR_W, req0_data_in input DATA_W, req0_ready_out output 1: requester 0 (CPU path via memory_system).
REQ-007 SHALL have ports req1_valid_in input 1, req1_addr_in input ADDR_W, req1_data_in input DATA_W, req1_ready_out output 1: requester 1 (blitter).
REQ-008 SHALL have ports clear_start_in input 1 (start-clear pulse), clear_color_in input DATA_W (fill value), clear_busy_out output 1, clear_done_out output 1.
REQ-009 SHALL have ports fb_we_out output 1, fb_addr_out output ADDR_W, fb_data_out output DATA_W: frame-buffer write port.

Function
REQ-010 SHALL implement states IDLE and CLEAR; reset state IDLE.
REQ-011 In IDLE with clear_start_in=0, SHALL grant at most one requester per cycle; readyN_out is combinational from validN_in, state and the round-robin pointer.
REQ-012 Only one valid -> that requester's ready=1; both valid -> grant the requester not granted in the last accepted transfer; neither valid -> both ready=0.
REQ-013 A transfer occurs when validN_in && readyN_out; the pointer SHALL update only on a transfer; reset pointer favours req0.
REQ-014 On a transfer, SHALL register fb_we_out=1, fb_addr_out, fb_data_out from the granted requester at the next edge (1-cycle latency); no transfer -> fb_we_out=0 next cycle, addr/data hold.
REQ-015 Requesters SHALL hold addr/data stable while valid && !ready; the arbiter relies on this and latches inputs only on the transfer.
REQ-016 clear_start_in=1 in IDLE SHALL win over requests in that cycle: both ready=0, latch clear_color_in, counter=0, go to CLEAR next edge.
REQ-017 In CLEAR, SHALL emit one write per cycle: fb_we_out=1, fb_addr_out=counter, fb_data_out=latched color; counter increments by 1.
REQ-018 In CLEAR, both ready outputs SHALL be 0 and clear_busy_out=1; clear_start_in SHALL be ignored.
REQ-019 When counter = FB_DEPTH-1 is written, SHALL return to IDLE and pulse clear_done_out for exactly the next cycle; counter never wraps past FB_DEPTH-1.
REQ-020 A full clear SHALL take exactly FB_DEPTH cycles of fb_we_out=1, with no gaps.
REQ-021 Address arithmetic SHALL be unsigned ADDR_W bits; requester addresses >= FB_DEPTH SHALL still be accepted and forwarded unchanged (range checking is the frame buffer's job).

Reset
REQ-022 rst_in=0 SHALL immediately force state IDLE, pointer=req0, counter=0, fb_we_out=0, fb_addr_out=0, fb_data_out=0, clear_busy_out=0, clear_done_out=0, latched color=0.
REQ-023 Reset asserted mid-clear SHALL abort the clear with no clear_done_out pulse; after release the arbiter SHALL accept requests on the first cycle.

Structure
REQ-024 FB_DEPTH, ADDR_W, DATA_W defaults and the state enum SHALL live in the shared frame-buffer package, also used by frame_buffer and hdmi.
REQ-025 SHALL be a single module; the grant logic MAY be a sub-module rr_arbiter2 (2-way round-robin, combinational grant plus registered pointer).

Verification
REQ-026 req0 only valid, addr=0x0010, data=0xF800 -> req0_ready=1 same cycle; next cycle fb_we=1, addr=0x0010, data=0xF800.
REQ-027 Both valid for 4 cycles after reset -> grants alternate req0,req1,req0,req1; four writes out, 1-cycle latency each.
REQ-028 clear_start with color 0x001F, FB_DEPTH overridden to 8 -> addrs 0..7 written with 0x001F on 8 consecutive cycles, busy high throughout, done pulses once, then IDLE.
REQ-029 clear_start and req1 valid in the same IDLE cycle -> req1_ready=0; req1 accepted on the first cycle after clear_done.
REQ-030 rst_in low at counter=3 of clear -> outputs zero at once, no done pulse; after release req0 write accepted on first cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry defaults and write-arbiter state encoding.
package fb_pkg;

    localparam int FB_DEPTH_DEF = 57600;
    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;

    typedef logic [0:0] fb_state_t;

    localparam fb_state_t ST_IDLE  = 1'b0;
    localparam fb_state_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: combinational grant, pointer registered on each grant.
module rr_arbiter2 (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       en_in,
    input  logic [1:0] req_in,
    output logic [1:0] gnt_out
);

    // prio_q=0 favours requester 0 on a tie, prio_q=1 favours requester 1.
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_out = 2'b00;
        if (en_in) begin
            if (req_in == 2'b11) begin
                gnt_out = prio_q ? 2'b10 : 2'b01;
            end else begin
                gnt_out = req_in;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt_out[0]) begin
            prio_d = 1'b1;
        end else if (gnt_out[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write port shared by two requesters plus a hardware clear engine.
// Handshake: a transfer happens in any cycle with valid && ready; requesters hold addr/data while valid && !ready.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int FB_DEPTH = FB_DEPTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req0_valid_in,
    input  logic [ADDR_W-1:0] req0_addr_in,
    input  logic [DATA_W-1:0] req0_data_in,
    output logic              req0_ready_out,
    input  logic              req1_valid_in,
    input  logic [ADDR_W-1:0] req1_addr_in,
    input  logic [DATA_W-1:0] req1_data_in,
    output logic              req1_ready_out,
    input  logic              clear_start_in,
    input  logic [DATA_W-1:0] clear_color_in,
    output logic              clear_busy_out,
    output logic              clear_done_out,
    output logic              fb_we_out,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [DATA_W-1:0] fb_data_out,
    output fb_state_t         dbg_state_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    fb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              arb_en;
    logic [1:0]        gnt;

    // A clear request in IDLE pre-empts both requesters in the same cycle.
    assign arb_en = (state_q == ST_IDLE) && !clear_start_in;

    rr_arbiter2 u_rr (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .en_in   (arb_en),
        .req_in  ({req1_valid_in, req0_valid_in}),
        .gnt_out (gnt)
    );

    assign req0_ready_out = gnt[0];
    assign req1_ready_out = gnt[1];
    assign clear_busy_out = (state_q == ST_CLEAR);
    assign clear_done_out = done_q;
    assign fb_we_out      = we_q;
    assign fb_addr_out    = addr_q;
    assign fb_data_out    = data_q;
    assign dbg_state_out  = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start_in) begin
                    state_d = ST_CLEAR;
                    color_d = clear_color_in;
                    cnt_d   = '0;
                end else if (gnt[0]) begin
                    we_d   = 1'b1;
                    addr_d = req0_addr_in;
                    data_d = req0_data_in;
                end else if (gnt[1]) begin
                    we_d   = 1'b1;
                    addr_d = req1_addr_in;
                    data_d = req1_data_in;
                end
            end
            ST_CLEAR: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = color_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a shrunken frame buffer (FB_DEPTH=8).
module tb_fb_write_arbiter;
    import fb_pkg::*;

    localparam int FB_DEPTH = 8;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              req0_valid_in;
    logic [ADDR_W-1:0] req0_addr_in;
    logic [DATA_W-1:0] req0_data_in;
    logic              req0_ready_out;
    logic              req1_valid_in;
    logic [ADDR_W-1:0] req1_addr_in;
    logic [DATA_W-1:0] req1_data_in;
    logic              req1_ready_out;
    logic              clear_start_in;
    logic [DATA_W-1:0] clear_color_in;
    logic              clear_busy_out;
    logic              clear_done_out;
    logic              fb_we_out;
    logic [ADDR_W-1:0] fb_addr_out;
    logic [DATA_W-1:0] fb_data_out;
    fb_state_t         dbg_state_out;

    int n_checks = 0;
    int n_pass   = 0;

    fb_write_arbiter #(
        .FB_DEPTH (FB_DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req0_valid_in  (req0_valid_in),
        .req0_addr_in   (req0_addr_in),
        .req0_data_in   (req0_data_in),
        .req0_ready_out (req0_ready_out),
        .req1_valid_in  (req1_valid_in),
        .req1_addr_in   (req1_addr_in),
        .req1_data_in   (req1_data_in),
        .req1_ready_out (req1_ready_out),
        .clear_start_in (clear_start_in),
        .clear_color_in (clear_color_in),
        .clear_busy_out (clear_busy_out),
        .clear_done_out (clear_done_out),
        .fb_we_out      (fb_we_out),
        .fb_addr_out    (fb_addr_out),
        .fb_data_out    (fb_data_out),
        .dbg_state_out  (dbg_state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one clock and settle 1ns past the edge before sampling or driving.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        chk({tag, ".we"},   32'(fb_we_out),   32'd1);
        chk({tag, ".addr"}, 32'(fb_addr_out), 32'(a));
        chk({tag, ".data"}, 32'(fb_data_out), 32'(d));
    endtask

    task automatic pulse_reset();
        rst_in = 1'b0;
        step();
        step();
        rst_in = 1'b1;
    endtask

    initial begin
        rst_in         = 1'b0;
        req0_valid_in  = 1'b0;
        req0_addr_in   = '0;
        req0_data_in   = '0;
        req1_valid_in  = 1'b0;
        req1_addr_in   = '0;
        req1_data_in   = '0;
        clear_start_in = 1'b0;
        clear_color_in = '0;
        step();
        step();

        chk("rst.we",    32'(fb_we_out),      32'd0);
        chk("rst.addr",  32'(fb_addr_out),    32'd0);
        chk("rst.data",  32'(fb_data_out),    32'd0);
        chk("rst.busy",  32'(clear_busy_out), 32'd0);
        chk("rst.done",  32'(clear_done_out), 32'd0);
        chk("rst.state", 32'(dbg_state_out),  32'(ST_IDLE));
        rst_in = 1'b1;

        // Single requester 0 write; address is above FB_DEPTH and forwarded unchanged.
        req0_valid_in = 1'b1;
        req0_addr_in  = 16'h0010;
        req0_data_in  = 16'hF800;
        #1;
        chk("single.rdy0", 32'(req0_ready_out), 32'd1);
        chk("single.rdy1", 32'(req1_ready_out), 32'd0);
        step();
        chk_write("single.wr", 16'h0010, 16'hF800);
        req0_valid_in = 1'b0;
        #1;
        chk("idle.rdy0", 32'(req0_ready_out), 32'd0);
        step();
        chk("idle.we",   32'(fb_we_out),   32'd0);
        chk("idle.addr", 32'(fb_addr_out), 32'h0010);
        chk("idle.data", 32'(fb_data_out), 32'hF800);

        // Both valid after reset: grants alternate 0,1,0,1.
        pulse_reset();
        req0_valid_in = 1'b1;
        req0_addr_in  = 16'h0100;
        req0_data_in  = 16'hAAAA;
        req1_valid_in = 1'b1;
        req1_addr_in  = 16'h0200;
        req1_data_in  = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d.rdy0", i), 32'(req0_ready_out), 32'((i % 2) == 0));
            chk($sformatf("rr%0d.rdy1", i), 32'(req1_ready_out), 32'((i % 2) == 1));
            step();
            if ((i % 2) == 0) chk_write($sformatf("rr%0d.wr", i), 16'h0100, 16'hAAAA);
            else              chk_write($sformatf("rr%0d.wr", i), 16'h0200, 16'h5555);
        end
        req0_valid_in = 1'b0;
        req1_valid_in = 1'b0;
        step();
        chk("rr.after.we", 32'(fb_we_out), 32'd0);

        // Clear collides with a req1 request; clear wins, req1 waits until the clear ends.
        clear_start_in = 1'b1;
        clear_color_in = 16'h001F;
        req1_valid_in  = 1'b1;
        req1_addr_in   = 16'h0300;
        req1_data_in   = 16'h1234;
        #1;
        chk("clr.start.rdy0", 32'(req0_ready_out), 32'd0);
        chk("clr.start.rdy1", 32'(req1_ready_out), 32'd0);
        step();
        clear_start_in = 1'b0;
        clear_color_in = 16'hFFFF;
        #1;
        chk("clr.c1.busy",  32'(clear_busy_out), 32'd1);
        chk("clr.c1.state", 32'(dbg_state_out),  32'(ST_CLEAR));
        chk("clr.c1.we",    32'(fb_we_out),      32'd0);
        chk("clr.c1.rdy1",  32'(req1_ready_out), 32'd0);
        for (int k = 0; k < FB_DEPTH; k++) begin
            step();
            clear_start_in = (k == 2);
            #1;
            chk_write($sformatf("clr.w%0d", k), ADDR_W'(k), 16'h001F);
            chk($sformatf("clr.w%0d.busy", k), 32'(clear_busy_out), 32'(k < FB_DEPTH - 1));
            chk($sformatf("clr.w%0d.done", k), 32'(clear_done_out), 32'(k == FB_DEPTH - 1));
            chk($sformatf("clr.w%0d.rdy1", k), 32'(req1_ready_out), 32'(k == FB_DEPTH - 1));
        end
        step();
        chk_write("clr.req1.wr", 16'h0300, 16'h1234);
        chk("clr.req1.done", 32'(clear_done_out), 32'd0);
        chk("clr.req1.state", 32'(dbg_state_out), 32'(ST_IDLE));
        req1_valid_in = 1'b0;
        step();

        // Reset while the clear counter is at 3 aborts it silently.
        clear_start_in = 1'b1;
        clear_color_in = 16'h07E0;
        step();
        clear_start_in = 1'b0;
        step();
        step();
        step();
        chk_write("abort.pre", 16'h0002, 16'h07E0);
        rst_in = 1'b0;
        #1;
        chk("abort.we",    32'(fb_we_out),      32'd0);
        chk("abort.addr",  32'(fb_addr_out),    32'd0);
        chk("abort.data",  32'(fb_data_out),    32'd0);
        chk("abort.busy",  32'(clear_busy_out), 32'd0);
        chk("abort.done",  32'(clear_done_out), 32'd0);
        chk("abort.state", 32'(dbg_state_out),  32'(ST_IDLE));
        step();
        step();
        rst_in        = 1'b1;
        req0_valid_in = 1'b1;
        req0_addr_in  = 16'h0042;
        req0_data_in  = 16'hBEEF;
        #1;
        chk("post.rdy0", 32'(req0_ready_out), 32'd1);
        step();
        chk_write("post.wr", 16'h0042, 16'hBEEF);
        chk("post.done", 32'(clear_done_out), 32'd0);
        req0_valid_in = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
